// File: rtl/rc_input_buffer.sv
// Per-port input flit buffer feeding BiNoC route computation: circular FIFO with
// req/gnt pop handshake, one upstream credit per pop, and sticky error flags.
module rc_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  req,
  output logic                  gnt,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  credit_out,
  output logic [AW:0]           count,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_pop;
  logic                  do_push;
  logic [AW:0]           count_nxt;

  // Accept decisions use the pre-edge count; a concurrent pop frees a slot for a push at full.
  always_comb begin
    do_pop    = req && (count != '0);
    do_push   = wr_en && ((count != FULL_CNT) || do_pop);
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + (AW + 1)'(1);
    else if (do_pop && !do_push)
      count_nxt = count - (AW + 1)'(1);
  end

  // Storage array is never reset; its contents are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[wr_ptr] <= wr_data;
  end

  // Registered control, status and read-data stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      gnt           <= 1'b0;
      credit_out    <= 1'b0;
      data_out      <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      gnt        <= do_pop;
      credit_out <= do_pop;
      count      <= count_nxt;
      empty      <= (count_nxt == '0);
      full       <= (count_nxt == FULL_CNT);
      if (wr_en && !do_push)
        overflow_err <= 1'b1;
      if (req && (count == '0))
        underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rc_input_buffer.sv
// Directed bench for rc_input_buffer: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_rc_input_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        req = 1'b0;
  logic        gnt;
  logic        empty;
  logic        full;
  logic [31:0] data_out;
  logic        credit_out;
  logic [2:0]  count;
  logic        overflow_err;
  logic        underflow_err;

  int compared = 0;
  int mismatched = 0;
  int gnt_cnt;
  int credit_cnt;
  int max_count;

  rc_input_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .req(req),
    .gnt(gnt), .empty(empty), .full(full), .data_out(data_out),
    .credit_out(credit_out), .count(count), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk({tag, "_gnt"}, gnt, 1);
    chk({tag, "_credit"}, credit_out, 1);
    chk({tag, "_data"}, data_out, d);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_credit", credit_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_unf", underflow_err, 0);

    // Basic push of three, pops two cycles apart
    push(32'hC000_0001);
    push(32'h4000_0002);
    push(32'h0000_0003);
    chk("t1_count3", count, 3);
    chk("t1_empty0", empty, 0);
    pop_expect("t1_pop1", 32'hC000_0001);
    chk("t1_count2", count, 2);
    tick();
    chk("t1_gnt_low", gnt, 0);
    chk("t1_credit_low", credit_out, 0);
    chk("t1_hold1", data_out, 32'hC000_0001);
    pop_expect("t1_pop2", 32'h4000_0002);
    tick();
    chk("t1_hold2", data_out, 32'h4000_0002);
    pop_expect("t1_pop3", 32'h0000_0003);
    chk("t1_empty1", empty, 1);
    chk("t1_count0", count, 0);
    tick();
    chk("t1_hold3", data_out, 32'h0000_0003);

    // Fill to full, then dropped fifth push
    push(32'h1111_1111);
    push(32'h2222_2222);
    push(32'h3333_3333);
    push(32'h4444_4444);
    chk("t2_full", full, 1);
    chk("t2_count4", count, 4);
    chk("t2_ovf_before", overflow_err, 0);
    push(32'hDEAD_BEEF);
    chk("t2_count_stay", count, 4);
    chk("t2_full_stay", full, 1);
    chk("t2_ovf", overflow_err, 1);
    pop_expect("t2_pop1", 32'h1111_1111);
    chk("t2_full_drop", full, 0);
    pop_expect("t2_pop2", 32'h2222_2222);
    pop_expect("t2_pop3", 32'h3333_3333);
    pop_expect("t2_pop4", 32'h4444_4444);
    chk("t2_empty", empty, 1);
    chk("t2_ovf_sticky", overflow_err, 1);
    do_reset();
    chk("t2_ovf_cleared", overflow_err, 0);

    // Simultaneous push and pop at full
    push(32'hA000_0001);
    push(32'hA000_0002);
    push(32'hA000_0003);
    push(32'hA000_0004);
    wr_en = 1'b1; wr_data = 32'h5555_5555; req = 1'b1;
    tick();
    wr_en = 1'b0; req = 1'b0;
    chk("t3_count", count, 4);
    chk("t3_full", full, 1);
    chk("t3_gnt", gnt, 1);
    chk("t3_data", data_out, 32'hA000_0001);
    chk("t3_ovf", overflow_err, 0);
    pop_expect("t3_pop2", 32'hA000_0002);
    pop_expect("t3_pop3", 32'hA000_0003);
    pop_expect("t3_pop4", 32'hA000_0004);
    pop_expect("t3_pop5", 32'h5555_5555);
    chk("t3_empty", empty, 1);

    // Push with req on an empty buffer
    wr_en = 1'b1; wr_data = 32'h1234_5678; req = 1'b1;
    tick();
    wr_en = 1'b0; req = 1'b0;
    chk("t4_gnt", gnt, 0);
    chk("t4_unf", underflow_err, 1);
    chk("t4_count", count, 1);
    chk("t4_empty", empty, 0);
    pop_expect("t4_pop", 32'h1234_5678);
    chk("t4_count0", count, 0);
    do_reset();
    chk("t4_unf_cleared", underflow_err, 0);

    // Streaming ten flits with wr_en and req both high
    gnt_cnt = 0; credit_cnt = 0; max_count = 0;
    push(32'h5000_0000);
    if (count > max_count) max_count = count;
    for (int i = 1; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 32'h5000_0000 + i; req = 1'b1;
      tick();
      gnt_cnt += gnt; credit_cnt += credit_out;
      if (count > max_count) max_count = count;
      chk($sformatf("t5_data%0d", i - 1), data_out, 32'h5000_0000 + i - 1);
    end
    wr_en = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    gnt_cnt += gnt; credit_cnt += credit_out;
    chk("t5_data9", data_out, 32'h5000_0009);
    tick();
    gnt_cnt += gnt; credit_cnt += credit_out;
    chk("t5_gnt_total", gnt_cnt, 10);
    chk("t5_credit_total", credit_cnt, 10);
    chk("t5_max_count", max_count, 1);
    chk("t5_ovf", overflow_err, 0);
    chk("t5_unf", underflow_err, 0);
    chk("t5_empty", empty, 1);

    // Reset mid-pop with three flits queued
    push(32'h7000_0001);
    push(32'h7000_0002);
    push(32'h7000_0003);
    chk("t6_count3", count, 3);
    rst = 1'b1; req = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_gnt", gnt, 0);
    chk("t6_data", data_out, 0);
    chk("t6_ovf", overflow_err, 0);
    chk("t6_unf", underflow_err, 0);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("t6_req_gnt", gnt, 0);
    chk("t6_req_credit", credit_out, 0);
    chk("t6_req_unf", underflow_err, 1);
    chk("t6_req_data", data_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
